// File: rtl/bcd_seq_alu_pkg.sv
// Purpose: op codes and FSM state encoding shared by the sequential BCD ALU and its bench.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional DIV states exist only when BCD_SEQ_ALU_DIV_EN is defined.
package bcd_seq_alu_pkg;

   // Three-bit op code leaves encodings 4..7 free, and these are rejected as unsupported.
   localparam int          OP_W   = 3;
   localparam logic [2:0]  OP_ADD = 3'd0;
   localparam logic [2:0]  OP_SUB = 3'd1;
   localparam logic [2:0]  OP_MUL = 3'd2;
   localparam logic [2:0]  OP_DIV = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADD       = 3'd1,
      S_SUB_FIX   = 3'd2,
      S_MUL_SHIFT = 3'd3,
      S_MUL_ADD   = 3'd4,
`ifdef BCD_SEQ_ALU_DIV_EN
      S_DIV_SHIFT = 3'd5,
      S_DIV_SUB   = 3'd6,
`endif
      S_DONE      = 3'd7
   } state_t;

endpackage

// File: rtl/bcd_seq_alu_nines.sv
// Purpose: per-digit 9's complement (9 - d) of a packed BCD word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module bcd_seq_alu_nines #(
   parameter int DIGITS = 4
) (
   input  logic [DIGITS*4-1:0] i_num,
   output logic [DIGITS*4-1:0] o_num
);

   genvar g;
   for (g = 0; g < DIGITS; g++) begin : g_dig
      assign o_num[g*4 +: 4] = 4'd9 - i_num[g*4 +: 4];
   end

endmodule

// File: rtl/bcd_seq_alu.sv
// Purpose: multi-cycle BCD ALU (ADD, signed SUB, MUL, optional DIV via BCD_SEQ_ALU_DIV_EN).
// Latency: ADD 2, SUB 3, MUL 2+N+sum(b digits), DIV 2+N+sum(q digits), error 1 cycle.
// Backpressure: start/busy/done; i_start ignored while o_busy, results held until next start.
module bcd_seq_alu
   import bcd_seq_alu_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CNT_WIDTH  = $clog2(NUM_DIGITS + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [OP_W-1:0]         i_op_code,
   input  logic [NUM_DIGITS*4-1:0] i_num_a,
   input  logic [NUM_DIGITS*4-1:0] i_num_b,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [NUM_DIGITS*4-1:0] o_num,
   output logic [NUM_DIGITS*4-1:0] o_rem,
   output logic                    o_neg,
   output logic                    o_ovf,
   output logic                    o_err,
   output logic                    o_zero
);

   localparam int W  = NUM_DIGITS * 4;
   localparam int WX = W + 4;            // one spare digit: carry digit, and r*10 during DIV
`ifdef BCD_SEQ_ALU_DIV_EN
   localparam int NC_W = WX;
`else
   localparam int NC_W = W;
`endif

   state_t                r_state;
   logic [OP_W-1:0]       r_op;
   logic [W-1:0]          r_a;
   logic [W-1:0]          r_b;
   logic [W-1:0]          r_acc;        // sum / difference / product / quotient
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [3:0]            r_units;
   logic                  r_carry;
   logic                  r_busy;
   logic                  r_done;
   logic [W-1:0]          r_num;
   logic                  r_neg;
   logic                  r_ovf;
   logic                  r_err;
   logic                  r_zero;
`ifdef BCD_SEQ_ALU_DIV_EN
   logic [WX-1:0]         r_rem;
   logic [W-1:0]          r_orem;
   logic [WX-1:0]         w_rem_shift;
   logic                  w_ge_shift;
   logic                  w_ge_sub;
`endif

   logic [NC_W-1:0]       w_nc_in;
   logic [NC_W-1:0]       w_nines;
   logic [WX-1:0]         w_add_x;
   logic [WX-1:0]         w_add_y;
   logic                  w_add_cin;
   logic [WX-1:0]         w_sum;
   logic [4:0]            w_dsum;
   logic                  w_c;
   logic                  w_carry;

   bcd_seq_alu_nines #(.DIGITS(NC_W / 4)) u_nines (
      .i_num (w_nc_in),
      .o_num (w_nines)
   );

   // Operand steering for the single shared adder and the complementer.
   always_comb begin
      w_nc_in   = '0;
      w_nc_in[W-1:0] = r_b;
      w_add_x   = {4'h0, r_a};
      w_add_y   = {4'h0, r_b};
      w_add_cin = 1'b0;
      case (r_state)
         S_ADD: begin
            if (r_op == OP_SUB) begin
               // a + 9's(b) + 1; the spare digit stays 0 so it reports the carry.
               w_add_y   = {4'h0, w_nines[W-1:0]};
               w_add_cin = 1'b1;
            end
         end
         S_SUB_FIX: begin
            // 10's complement of the negative-range sum: 0 + 9's(acc) + 1.
            w_nc_in[W-1:0] = r_acc;
            w_add_x   = '0;
            w_add_y   = {4'h0, w_nines[W-1:0]};
            w_add_cin = 1'b1;
         end
         S_MUL_ADD: begin
            w_add_x = {4'h0, r_acc};
            w_add_y = {4'h0, r_a};
         end
`ifdef BCD_SEQ_ALU_DIV_EN
         S_DIV_SUB: begin
            // r - b over the full remainder width; final carry is discarded since r >= b.
            w_add_x   = r_rem;
            w_add_y   = w_nines;
            w_add_cin = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Ripple BCD adder across all digits including the spare carry digit.
   always_comb begin
      w_sum  = '0;
      w_dsum = '0;
      w_c    = w_add_cin;
      for (int i = 0; i < NUM_DIGITS + 1; i++) begin
         w_dsum = {1'b0, w_add_x[i*4 +: 4]} + {1'b0, w_add_y[i*4 +: 4]} + {4'b0, w_c};
         if (w_dsum > 5'd9) begin
            w_sum[i*4 +: 4] = 4'(w_dsum - 5'd10);
            w_c             = 1'b1;
         end else begin
            w_sum[i*4 +: 4] = w_dsum[3:0];
            w_c             = 1'b0;
         end
      end
   end

   // Spare digit of the sum is 0 or 1 for the N-digit ops, so any set bit is the carry.
   assign w_carry = |w_sum[WX-1:W];

`ifdef BCD_SEQ_ALU_DIV_EN
   // Packed BCD orders the same as its value, so a plain unsigned compare is r >= b.
   assign w_rem_shift = {r_rem[W-1:0], r_a[W-1 -: 4]};
   assign w_ge_shift  = w_rem_shift >= {4'h0, r_b};
   assign w_ge_sub    = w_sum >= {4'h0, r_b};
`endif

   // Control FSM with all datapath and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_units <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_num   <= '0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
         r_zero  <= 1'b1;
`ifdef BCD_SEQ_ALU_DIV_EN
         r_rem   <= '0;
         r_orem  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_op    <= i_op_code;
                  r_a     <= i_num_a;
                  r_b     <= i_num_b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_units <= '0;
                  r_carry <= 1'b0;
                  r_neg   <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
`ifdef BCD_SEQ_ALU_DIV_EN
                  r_rem   <= '0;
                  r_orem  <= '0;
`endif
                  case (i_op_code)
                     OP_ADD, OP_SUB: r_state <= S_ADD;
                     OP_MUL:         r_state <= S_MUL_SHIFT;
`ifdef BCD_SEQ_ALU_DIV_EN
                     OP_DIV: begin
                        if (i_num_b == '0) begin
                           r_err   <= 1'b1;
                           r_state <= S_DONE;
                        end else begin
                           r_state <= S_DIV_SHIFT;
                        end
                     end
`endif
                     default: begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                     end
                  endcase
               end
            end
            S_ADD: begin
               r_acc   <= w_sum[W-1:0];
               r_carry <= w_carry;
               if (r_op == OP_ADD) begin
                  r_ovf   <= w_carry;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_SUB_FIX;
               end
            end
            S_SUB_FIX: begin
               // No carry means a < b: the sum is 10^N - (b - a), so negate it.
               if (!r_carry) begin
                  r_acc <= w_sum[W-1:0];
                  r_neg <= 1'b1;
               end
               r_state <= S_DONE;
            end
            S_MUL_SHIFT: begin
               // The visit after the last digit only hands over to DONE.
               if (r_cnt == CNT_WIDTH'(NUM_DIGITS)) begin
                  r_state <= S_DONE;
               end else begin
                  if (r_acc[W-1 -: 4] != 4'h0) r_ovf <= 1'b1;
                  r_acc   <= r_acc << 4;
                  r_b     <= r_b << 4;
                  r_units <= r_b[W-1 -: 4];
                  r_cnt   <= r_cnt + CNT_WIDTH'(1);
                  if (r_b[W-1 -: 4] != 4'h0) r_state <= S_MUL_ADD;
               end
            end
            S_MUL_ADD: begin
               r_acc   <= w_sum[W-1:0];
               if (w_carry) r_ovf <= 1'b1;
               r_units <= r_units - 4'd1;
               if (r_units == 4'd1) r_state <= S_MUL_SHIFT;
            end
`ifdef BCD_SEQ_ALU_DIV_EN
            S_DIV_SHIFT: begin
               if (r_cnt == CNT_WIDTH'(NUM_DIGITS)) begin
                  r_state <= S_DONE;
               end else begin
                  r_rem <= w_rem_shift;
                  r_acc <= r_acc << 4;
                  r_a   <= r_a << 4;
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
                  if (w_ge_shift) r_state <= S_DIV_SUB;
               end
            end
            S_DIV_SUB: begin
               // Quotient digit is below 9 here, so the low digit never carries.
               r_rem        <= w_sum;
               r_acc[3:0]   <= r_acc[3:0] + 4'd1;
               if (!w_ge_sub) r_state <= S_DIV_SHIFT;
            end
`endif
            S_DONE: begin
               r_num   <= r_acc;
               r_zero  <= (r_acc == '0);
`ifdef BCD_SEQ_ALU_DIV_EN
               r_orem  <= r_rem[W-1:0];
`endif
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_num  = r_num;
   assign o_neg  = r_neg;
   assign o_ovf  = r_ovf;
   assign o_err  = r_err;
   assign o_zero = r_zero;
`ifdef BCD_SEQ_ALU_DIV_EN
   assign o_rem  = r_orem;
`else
   assign o_rem  = '0;
`endif

endmodule

// File: tb/tb_bcd_seq_alu.sv
// Purpose: self-checking bench for bcd_seq_alu against an integer-arithmetic reference.
// Latency: checks exact start-to-done cycle counts for every operation.
// Backpressure: exercises start-while-busy, back-to-back starts and mid-operation reset.
module tb_bcd_seq_alu;
   import bcd_seq_alu_pkg::*;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_start;
   logic [OP_W-1:0] i_op_code;
   logic [15:0]     i_num_a;
   logic [15:0]     i_num_b;
   logic            o_busy;
   logic            o_done;
   logic [15:0]     o_num;
   logic [15:0]     o_rem;
   logic            o_neg;
   logic            o_ovf;
   logic            o_err;
   logic            o_zero;

   int n_cmp = 0;
   int n_err = 0;

   bcd_seq_alu #(.NUM_DIGITS(4)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .i_op_code (i_op_code),
      .i_num_a   (i_num_a),
      .i_num_b   (i_num_b),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_num     (o_num),
      .o_rem     (o_rem),
      .o_neg     (o_neg),
      .o_ovf     (o_ovf),
      .o_err     (o_err),
      .o_zero    (o_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int digit_sum(input int v);
      int s;
      int t;
      s = 0;
      t = v;
      while (t > 0) begin
         s = s + t % 10;
         t = t / 10;
      end
      return s;
   endfunction

   function automatic int rand_dec();
      int nd;
      nd = $urandom_range(0, 4);
      return (nd == 0) ? 0 : $urandom_range(0, (10 ** nd) - 1);
   endfunction

   // One operation: drive start, wait for done with a cycle budget, compare against the model.
   task automatic run_op(input logic [OP_W-1:0] op, input int a, input int b, input bit poke);
      int    e_num, e_rem, e_lat, lat;
      bit    e_neg, e_ovf, e_err, busy_ok, done;
      string id;
      e_num = 0; e_rem = 0; e_neg = 0; e_ovf = 0; e_err = 0; e_lat = 1;
      case (op)
         OP_ADD: begin
            e_num = (a + b) % 10000; e_ovf = (a + b) >= 10000; e_lat = 2;
         end
         OP_SUB: begin
            e_neg = a < b; e_num = (a >= b) ? a - b : b - a; e_lat = 3;
         end
         OP_MUL: begin
            e_num = (a * b) % 10000; e_ovf = (a * b) >= 10000; e_lat = 6 + digit_sum(b);
         end
`ifdef BCD_SEQ_ALU_DIV_EN
         OP_DIV: begin
            if (b == 0) begin
               e_err = 1; e_lat = 1;
            end else begin
               e_num = a / b; e_rem = a % b; e_lat = 6 + digit_sum(a / b);
            end
         end
`endif
         default: begin
            e_err = 1; e_lat = 1;
         end
      endcase
      id = $sformatf("op%0d %0d,%0d", op, a, b);

      i_op_code = op;
      i_num_a   = to_bcd(a);
      i_num_b   = to_bcd(b);
      i_start   = 1'b1;
      @(posedge i_clk); #1;
      i_start   = 1'b0;
      i_op_code = OP_W'($urandom_range(0, 7));
      i_num_a   = to_bcd($urandom_range(0, 9999));
      i_num_b   = to_bcd($urandom_range(0, 9999));
      busy_ok = o_busy;
      done    = 1'b0;
      lat     = 0;
      while (!done && lat < 300) begin
         if (poke) i_start = (lat == 2);
         @(posedge i_clk); #1;
         lat++;
         if (o_done) done = 1'b1;
         else if (!o_busy) busy_ok = 1'b0;
      end
      i_start = 1'b0;
      check_val({"lat ", id}, lat, e_lat);
      check_val({"busy ", id}, busy_ok, 1);
      check_val({"num ", id}, o_num, to_bcd(e_num));
      check_val({"rem ", id}, o_rem, to_bcd(e_rem));
      check_val({"neg ", id}, o_neg, e_neg);
      check_val({"ovf ", id}, o_ovf, e_ovf);
      check_val({"err ", id}, o_err, e_err);
      check_val({"zero ", id}, o_zero, e_num == 0);
      check_val({"busy_at_done ", id}, o_busy, 0);
   endtask

   initial begin
      int nd;
      int a;
      int b;
      int sel;
      logic [OP_W-1:0] op;

      i_rst = 1'b1; i_start = 1'b0; i_op_code = '0; i_num_a = '0; i_num_b = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check_val("rst busy", o_busy, 0);
      check_val("rst done", o_done, 0);
      check_val("rst num",  o_num, 0);
      check_val("rst rem",  o_rem, 0);
      check_val("rst flags", {o_neg, o_ovf, o_err}, 0);
      check_val("rst zero", o_zero, 1);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // Directed cases; consecutive calls start in the previous done cycle.
      run_op(OP_ADD, 1234, 8766, 0);
      run_op(OP_SUB, 5, 12, 0);
      run_op(OP_SUB, 12, 12, 0);
      run_op(OP_MUL, 123, 45, 0);
      run_op(OP_MUL, 9999, 2, 0);
      run_op(OP_MUL, 0, 9999, 0);
      run_op(OP_DIV, 1000, 7, 0);
      run_op(OP_DIV, 42, 0, 0);
      run_op(OP_DIV, 3, 9999, 0);
      run_op(3'd5, 1, 1, 0);
      run_op(OP_ADD, 9999, 9999, 0);
      run_op(OP_MUL, 123, 45, 1);

      // Reset in the middle of a long multiply.
      i_op_code = OP_MUL; i_num_a = to_bcd(9999); i_num_b = to_bcd(9999); i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (5) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      check_val("midrst busy", o_busy, 0);
      check_val("midrst done", o_done, 0);
      check_val("midrst num", o_num, 0);
      check_val("midrst flags", {o_neg, o_ovf, o_err}, 0);
      check_val("midrst zero", o_zero, 1);
      nd = 0;
      repeat (60) begin
         @(posedge i_clk); #1;
         if (o_done || o_busy) nd++;
      end
      check_val("midrst quiet", nd, 0);

      // Randomized mix of operations and operand magnitudes.
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         a = rand_dec();
         b = ($urandom_range(0, 7) == 0) ? a : rand_dec();
         if (sel < 3)      op = OP_ADD;
         else if (sel < 5) op = OP_SUB;
         else if (sel < 7) op = OP_MUL;
         else if (sel < 9) op = OP_DIV;
         else              op = OP_W'($urandom_range(4, 7));
         run_op(op, a, b, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
